// File: rtl/gcd_host_sequencer.sv
// Host-side sequencer for a GCD coprocessor: replays a small table of operand pairs
// through a val/rdy interface and checks returned results against expected values.
module gcd_host_sequencer #(
    parameter int unsigned W       = 16,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned TIMEOUT = 1024,
    localparam int unsigned AW     = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cfg_we,
    input  logic [AW-1:0] cfg_addr,
    input  logic [W-1:0]  cfg_A,
    input  logic [W-1:0]  cfg_B,
    input  logic [W-1:0]  cfg_expect,
    input  logic [AW:0]   cfg_count,
    input  logic          start,
    output logic          operands_val,
    output logic [W-1:0]  operands_bits_A,
    output logic [W-1:0]  operands_bits_B,
    input  logic          operands_rdy,
    input  logic          result_val,
    input  logic [W-1:0]  result_bits,
    output logic          result_rdy,
    output logic          busy,
    output logic          done,
    output logic          timeout,
    output logic [AW:0]   pass_count,
    output logic [AW:0]   fail_count,
    output logic [AW-1:0] first_fail_idx,
    output logic          any_fail
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e        state_q, state_d;
    logic [W-1:0]  a_mem [DEPTH];
    logic [W-1:0]  b_mem [DEPTH];
    logic [W-1:0]  e_mem [DEPTH];
    logic [AW:0]   count_q, count_d;
    logic [AW:0]   issue_q, issue_d;
    logic [AW:0]   check_q, check_d;
    logic [AW:0]   pass_q, pass_d;
    logic [AW:0]   fail_q, fail_d;
    logic [AW-1:0] first_q, first_d;
    logic          any_q, any_d;
    logic          done_q, done_d;
    logic          tmo_flag_q, tmo_flag_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          op_val_q, op_val_d;
    logic [W-1:0]  op_a_q, op_a_d;
    logic [W-1:0]  op_b_q, op_b_d;
    logic          issue_fire, result_fire;

    // Table is not reset so vectors survive a reset between runs.
    always_ff @(posedge clk) begin
        if (cfg_we && state_q != StRun) begin
            a_mem[cfg_addr] <= cfg_A;
            b_mem[cfg_addr] <= cfg_B;
            e_mem[cfg_addr] <= cfg_expect;
        end
    end

    assign result_rdy  = (state_q == StRun) && (check_q < count_q);
    assign issue_fire  = op_val_q && operands_rdy;
    assign result_fire = result_val && result_rdy;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        issue_d    = issue_q;
        check_d    = check_q;
        pass_d     = pass_q;
        fail_d     = fail_q;
        first_d    = first_q;
        any_d      = any_q;
        done_d     = done_q;
        tmo_flag_d = tmo_flag_q;
        tmo_d      = tmo_q;
        op_val_d   = 1'b0;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    count_d    = cfg_count;
                    issue_d    = '0;
                    check_d    = '0;
                    pass_d     = '0;
                    fail_d     = '0;
                    any_d      = 1'b0;
                    tmo_flag_d = 1'b0;
                    tmo_d      = '0;
                    if (cfg_count == '0) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                    end else begin
                        state_d = StRun;
                        done_d  = 1'b0;
                    end
                end
            end
            StRun: begin
                if (issue_fire) begin
                    issue_d = issue_q + (AW+1)'(1);
                end
                if (result_fire) begin
                    check_d = check_q + (AW+1)'(1);
                    tmo_d   = '0;
                    if (result_bits == e_mem[check_q[AW-1:0]]) begin
                        pass_d = pass_q + (AW+1)'(1);
                    end else begin
                        fail_d = fail_q + (AW+1)'(1);
                        if (!any_q) begin
                            any_d   = 1'b1;
                            first_d = check_q[AW-1:0];
                        end
                    end
                    if (check_d == count_q) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                    end
                end else begin
                    tmo_d = tmo_q + TW'(1);
                    if (tmo_d == TW'(TIMEOUT)) begin
                        state_d    = StDone;
                        done_d     = 1'b1;
                        tmo_flag_d = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Operands are registered: look ahead at the next issue index.
        if (state_d == StRun && issue_d < count_d) begin
            op_val_d = 1'b1;
            op_a_d   = a_mem[issue_d[AW-1:0]];
            op_b_d   = b_mem[issue_d[AW-1:0]];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            count_q    <= '0;
            issue_q    <= '0;
            check_q    <= '0;
            pass_q     <= '0;
            fail_q     <= '0;
            first_q    <= '0;
            any_q      <= 1'b0;
            done_q     <= 1'b0;
            tmo_flag_q <= 1'b0;
            tmo_q      <= '0;
            op_val_q   <= 1'b0;
            op_a_q     <= '0;
            op_b_q     <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            issue_q    <= issue_d;
            check_q    <= check_d;
            pass_q     <= pass_d;
            fail_q     <= fail_d;
            first_q    <= first_d;
            any_q      <= any_d;
            done_q     <= done_d;
            tmo_flag_q <= tmo_flag_d;
            tmo_q      <= tmo_d;
            op_val_q   <= op_val_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
        end
    end

    assign operands_val    = op_val_q;
    assign operands_bits_A = op_a_q;
    assign operands_bits_B = op_b_q;
    assign busy            = (state_q == StRun);
    assign done            = done_q;
    assign timeout         = tmo_flag_q;
    assign pass_count      = pass_q;
    assign fail_count      = fail_q;
    assign first_fail_idx  = first_q;
    assign any_fail        = any_q;

endmodule

// File: tb/tb_gcd_host_sequencer.sv
// Scoreboard bench for gcd_host_sequencer: a GCD responder feeds results back, and a
// monitor checks issued operands and end-of-run tallies against a table-level model.
module tb_gcd_host_sequencer;

    localparam int W       = 16;
    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 16;
    localparam int AW      = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cfg_we = 1'b0;
    logic [AW-1:0] cfg_addr = '0;
    logic [W-1:0]  cfg_A = '0, cfg_B = '0, cfg_expect = '0;
    logic [AW:0]   cfg_count = '0;
    logic          start = 1'b0;
    logic          operands_val;
    logic [W-1:0]  operands_bits_A, operands_bits_B;
    logic          operands_rdy = 1'b0;
    logic          result_val = 1'b0;
    logic [W-1:0]  result_bits = '0;
    logic          result_rdy, busy, done, timeout, any_fail;
    logic [AW:0]   pass_count, fail_count;
    logic [AW-1:0] first_fail_idx;

    always #5 clk = ~clk;

    gcd_host_sequencer #(.W(W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_A(cfg_A),
        .cfg_B(cfg_B), .cfg_expect(cfg_expect), .cfg_count(cfg_count), .start(start),
        .operands_val(operands_val), .operands_bits_A(operands_bits_A),
        .operands_bits_B(operands_bits_B), .operands_rdy(operands_rdy),
        .result_val(result_val), .result_bits(result_bits), .result_rdy(result_rdy),
        .busy(busy), .done(done), .timeout(timeout), .pass_count(pass_count),
        .fail_count(fail_count), .first_fail_idx(first_fail_idx), .any_fail(any_fail)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [W-1:0] a; logic [W-1:0] b; } op_t;
    typedef struct { int pass; int fail; int any; int first; int tmo; } end_t;
    typedef struct { logic [W-1:0] v; int rdy_at; } rsp_t;

    logic [W-1:0] t_a [DEPTH];
    logic [W-1:0] t_b [DEPTH];
    logic [W-1:0] t_e [DEPTH];
    op_t  exp_ops [$];
    end_t exp_end [$];
    rsp_t rsp_q [$];
    bit   resp_en = 1'b1;
    bit   rdy_all = 1'b0;
    int   stall_left = 0;
    int   end_cyc = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int gcd_f(int a, int b);
        int t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // Monitor + GCD responder in one process so sampling and driving never race.
    logic         op_fire, res_fire, hold_pend = 1'b0, done_prev = 1'b0;
    logic [W-1:0] hold_a, hold_b, snap_a, snap_b;
    op_t          o;
    end_t         e;
    rsp_t         r;

    always begin
        @(negedge clk);
        op_fire  = operands_val && operands_rdy && !reset;
        res_fire = result_val && result_rdy && !reset;
        snap_a   = operands_bits_A;
        snap_b   = operands_bits_B;
        if (hold_pend && !reset && busy) begin
            check("hold_val", operands_val, 1);
            check("hold_A", operands_bits_A, hold_a);
            check("hold_B", operands_bits_B, hold_b);
        end
        hold_pend = operands_val && !operands_rdy && !reset;
        hold_a    = operands_bits_A;
        hold_b    = operands_bits_B;
        if (op_fire) begin
            if (exp_ops.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_operand: got A=%0d B=%0d, expected none", snap_a, snap_b);
            end else begin
                o = exp_ops.pop_front();
                check("op_A", snap_a, o.a);
                check("op_B", snap_b, o.b);
            end
        end
        if (done && !done_prev && !reset) begin
            end_cyc = cyc;
            if (exp_end.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_done: got done=1, expected no run ending");
            end else begin
                e = exp_end.pop_front();
                check("pass_count", pass_count, e.pass);
                check("fail_count", fail_count, e.fail);
                check("any_fail", any_fail, e.any);
                if (e.any != 0) check("first_fail_idx", first_fail_idx, e.first);
                check("timeout", timeout, e.tmo);
                check("end_op_val", operands_val, 0);
                check("end_busy", busy, 0);
                check("end_result_rdy", result_rdy, 0);
            end
        end
        done_prev = done;
        @(posedge clk);
        #1;
        if (res_fire && rsp_q.size() > 0) void'(rsp_q.pop_front());
        if (op_fire) begin
            r.v      = W'(gcd_f(int'(snap_a), int'(snap_b)));
            r.rdy_at = cyc + $urandom_range(0, 3);
            rsp_q.push_back(r);
        end
        if (stall_left > 0) begin
            operands_rdy = 1'b0;
            stall_left--;
        end else begin
            operands_rdy = rdy_all || ($urandom_range(0, 3) != 0);
        end
        result_val  = resp_en && rsp_q.size() > 0 && rsp_q[0].rdy_at <= cyc;
        result_bits = (rsp_q.size() > 0) ? rsp_q[0].v : '0;
    end

    task automatic wr(int i, int a, int b, int ex);
        cfg_we = 1'b1;
        cfg_addr = AW'(i);
        cfg_A = W'(a);
        cfg_B = W'(b);
        cfg_expect = W'(ex);
        t_a[i] = W'(a);
        t_b[i] = W'(b);
        t_e[i] = W'(ex);
        @(posedge clk);
        #2;
        cfg_we = 1'b0;
    endtask

    task automatic launch(int cnt, bit tmo_mode, output int s_cyc);
        op_t  op;
        end_t ee;
        ee = '{pass: 0, fail: 0, any: 0, first: 0, tmo: 0};
        for (int i = 0; i < cnt; i++) begin
            op.a = t_a[i];
            op.b = t_b[i];
            exp_ops.push_back(op);
            if (tmo_mode) continue;
            if (int'(t_e[i]) == gcd_f(int'(t_a[i]), int'(t_b[i]))) ee.pass++;
            else begin
                ee.fail++;
                if (ee.any == 0) begin
                    ee.any = 1;
                    ee.first = i;
                end
            end
        end
        if (tmo_mode) ee.tmo = 1;
        exp_end.push_back(ee);
        cfg_count = (AW+1)'(cnt);
        start = 1'b1;
        @(posedge clk);
        #2;
        s_cyc = cyc;
        start = 1'b0;
    endtask

    task automatic wait_end(string name);
        int n = 0;
        while (exp_end.size() > 0 && n < 400) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (exp_end.size() > 0) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: got no done within 400 cycles, expected run end", name);
            exp_end.delete();
        end
        check({name, "_ops_left"}, exp_ops.size(), 0);
        exp_ops.delete();
    endtask

    task automatic check_idle(string name);
        check({name, "_op_val"}, operands_val, 0);
        check({name, "_op_A"}, operands_bits_A, 0);
        check({name, "_op_B"}, operands_bits_B, 0);
        check({name, "_result_rdy"}, result_rdy, 0);
        check({name, "_busy"}, busy, 0);
        check({name, "_done"}, done, 0);
        check({name, "_timeout"}, timeout, 0);
        check({name, "_pass"}, pass_count, 0);
        check({name, "_fail"}, fail_count, 0);
        check({name, "_first"}, first_fail_idx, 0);
        check({name, "_any"}, any_fail, 0);
    endtask

    initial begin
        int s;
        int n;
        int a;
        int b;
        int g;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        check_idle("reset");

        wr(0, 7, 7, 7);
        wr(1, 12, 8, 4);
        wr(2, 200, 35, 5);
        wr(3, 15, 9, 3);
        wr(4, 99, 36, 9);
        wr(5, 1, 2, 1);
        wr(6, 144, 168, 24);

        launch(0, 1'b0, s);
        wait_end("count0");
        check("count0_latency", end_cyc - s, 0);

        launch(7, 1'b0, s);
        wait_end("all_pass");

        wr(2, 200, 35, 6);
        launch(7, 1'b0, s);
        wait_end("one_fail");
        wr(2, 200, 35, 5);

        launch(7, 1'b0, s);
        repeat (2) @(posedge clk);
        #2;
        stall_left = 5;
        wait_end("stall");

        resp_en = 1'b0;
        rdy_all = 1'b1;
        launch(3, 1'b0, s);
        exp_end.delete();
        exp_end.push_back('{pass: 0, fail: 0, any: 0, first: 0, tmo: 1});
        wait_end("timeout");
        check("timeout_latency", end_cyc - s, TIMEOUT);
        rsp_q.delete();
        resp_en = 1'b1;
        rdy_all = 1'b0;

        launch(7, 1'b0, s);
        n = 0;
        while (pass_count != 3 && n < 200) begin
            @(posedge clk);
            #2;
            n++;
        end
        check("pre_reset_pass", pass_count, 3);
        reset = 1'b1;
        exp_ops.delete();
        exp_end.delete();
        rsp_q.delete();
        result_val = 1'b0;
        result_bits = '0;
        #1;
        check("async_drop_op_val", operands_val, 0);
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        check_idle("midrun_reset");
        launch(7, 1'b0, s);
        wait_end("restart");

        for (int run = 0; run < 6; run++) begin
            for (int i = 0; i < DEPTH; i++) begin
                a = $urandom_range(1, 600);
                b = $urandom_range(1, 600);
                g = gcd_f(a, b);
                wr(i, a, b, ($urandom_range(0, 3) == 0) ? g + 1 : g);
            end
            launch($urandom_range(1, DEPTH), 1'b0, s);
            wait_end("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish by 500000, expected earlier end");
        $fatal(1);
    end

endmodule

// File: doc/gcd_host_sequencer.md
GCD_HOST_SEQUENCER -- requirements
Module: gcd_host_sequencer

Interface
REQ-001 SHALL have parameter W, default 16, meaning operand/result width.
REQ-002 SHALL have parameter DEPTH, default 8, meaning vector table entries (power of 2); AW = log2(DEPTH).
REQ-003 SHALL have parameter TIMEOUT, default 1024, meaning maximum RUN cycles allowed without a result transfer.
REQ-004 SHALL have one clock and one reset; reset is asynchronous and active-high. Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high
- cfg_we  input  1  table write strobe
- cfg_addr  input  AW  table write index
- cfg_A, cfg_B, cfg_expect  input  W each  operand pair and expected GCD
- cfg_count  input  AW+1  number of vectors to run, 0..DEPTH
- start  input  1  one-cycle run request
- operands_val  output  1  operand pair valid
- operands_bits_A, operands_bits_B  output  W each  operand pair
- operands_rdy  input  1  coprocessor accepts operands
- result_val  input  1  coprocessor result valid
- result_bits  input  W  coprocessor result
- result_rdy  output  1  sequencer accepts result
- busy  output  1  state is RUN
- done  output  1  run finished, held until next start or reset
- timeout  output  1  run ended by timeout
- pass_count, fail_count  output  AW+1 each  compare tallies
- first_fail_idx  output  AW  index of first mismatch
- any_fail  output  1  first_fail_idx is valid

Function
REQ-005 SHALL implement states IDLE, RUN, DONE; reset enters IDLE.
REQ-006 SHALL write {cfg_A, cfg_B, cfg_expect} to table[cfg_addr] on cfg_we in IDLE or DONE; cfg_we in RUN ignored.
REQ-007 SHALL on start in IDLE or DONE latch cfg_count, clear issue_idx, check_idx, counts, timeout, any_fail, done, and enter RUN; start in RUN ignored.
REQ-008 SHALL, for latched count 0, go IDLE/DONE -> DONE in one cycle, counts 0, done=1.
REQ-009 SHALL assert operands_val in RUN while issue_idx < count, driving table[issue_idx] A/B, all registered outputs.
REQ-010 SHALL hold operands_val and bits stable until operands_val && operands_rdy at a rising edge, then increment issue_idx and present the next entry the following cycle (one transfer per cycle max, no bubble required).
REQ-011 SHALL drive result_rdy = (state==RUN) && (check_idx < count), combinationally.
REQ-012 SHALL on result_val && result_rdy compare result_bits to table[check_idx].expect: equal -> pass_count+1; unequal -> fail_count+1, and if any_fail==0 set any_fail=1 and first_fail_idx=check_idx; then increment check_idx.
REQ-013 SHALL accept results before all operands are issued; results are in issue order; issue and result transfers in the same cycle both take effect.
REQ-014 SHALL enter DONE, set done=1, and deassert operands_val and result_rdy the cycle after check_idx reaches count.
REQ-015 SHALL count RUN cycles since the last result transfer (cleared by each transfer and at start); on reaching TIMEOUT enter DONE with timeout=1, done=1, operands_val=0, counts frozen.
REQ-016 SHALL ignore result_val outside RUN (no count change).
REQ-017 SHALL keep busy=1 exactly in RUN.

Reset
REQ-018 SHALL on reset, regardless of state, force IDLE with operands_val=0, operands_bits=0, result_rdy=0, busy=0, done=0, timeout=0, pass_count=0, fail_count=0, first_fail_idx=0, any_fail=0; table contents unaffected.
REQ-019 SHALL, when reset asserts mid-RUN, drop operands_val asynchronously with no further transfers.

Verification
REQ-020 Load 7 vectors (7,7,7)(12,8,4)(200,35,5)(15,9,3)(99,36,9)(1,2,1)(144,168,24), count=7, ideal GCD responder -> pass_count=7, fail_count=0, any_fail=0, done=1, timeout=0.
REQ-021 Same table, entry 2 expect=6 -> pass_count=6, fail_count=1, first_fail_idx=2, any_fail=1.
REQ-022 operands_rdy held low 5 cycles mid-run -> operands_val and bits stable over those cycles, no vector skipped or repeated.
REQ-023 count=0, start -> done=1 next cycle, counts 0, no operands_val.
REQ-024 TIMEOUT=16, responder never asserts result_val -> done=1, timeout=1 after 16 RUN cycles, operands_val=0.
REQ-025 Reset asserted during RUN after 3 results, then restart with count=7 -> clean IDLE outputs, second run pass_count=7.
